// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 codes, FSM states, width default.
package muldiv_pkg;

   localparam int MULDIV_XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } muldiv_state_t;

   // rs1 is treated as signed for every op except the fully unsigned ones
   function automatic logic op_signed_a(input logic [2:0] f3);
      return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the register file side and the mul/div unit.
interface muldiv_unit_if
   import muldiv_pkg::*;
#(
   parameter int XLEN = MULDIV_XLEN
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            regwrite_out;

   modport master (
      output start, funct3, rs1_data, rs2_data, rd_in,
      input  busy, done, result, rd_out, regwrite_out
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_in,
      output busy, done, result, rd_out, regwrite_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add / restoring shift-subtract step per bit,
// sharing a single 2*XLEN accumulator and one XLEN+1-bit adder/subtractor.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = MULDIV_XLEN
) (
   input  logic         clock,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              sign_a_q;
   logic              sign_b_q;
   logic [XLEN-1:0]   opb_q;
   logic [2*XLEN-1:0] acc_q;
   logic [CW-1:0]     count_q;
   logic              busy_q;
   logic              done_q;
   logic              regwrite_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;

   logic              neg_a;
   logic              neg_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN-1:0]   special_res;

   always_comb begin
      neg_a    = op_signed_a(bus.funct3) & bus.rs1_data[XLEN-1];
      neg_b    = op_signed_b(bus.funct3) & bus.rs2_data[XLEN-1];
      mag_a    = neg_a ? -bus.rs1_data : bus.rs1_data;
      mag_b    = neg_b ? -bus.rs2_data : bus.rs2_data;
      div_zero = bus.funct3[2] && (bus.rs2_data == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                 (bus.rs1_data == MOST_NEG) && (bus.rs2_data == '1);
      // funct3[1] selects the remainder flavour among divide ops
      if (div_zero) special_res = bus.funct3[1] ? bus.rs1_data : '1;
      else          special_res = bus.funct3[1] ? '0 : bus.rs1_data;
   end

   // Divide feeds the shifted partial remainder (XLEN+1 bits) and subtracts;
   // multiply adds the multiplicand into the upper half.
   logic [XLEN:0]     add_a;
   logic [XLEN:0]     add_b;
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      add_a   = op_q[2] ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_b   = op_q[2] ? ~{1'b0, opb_q} : {1'b0, opb_q};
      add_sum = add_a + add_b + {{XLEN{1'b0}}, op_q[2]};
      if (op_q[2]) begin
         acc_step = add_sum[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quo  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         F3_MUL:                       fix_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_res = quo;
         default:                      fix_res = rem;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= '0;
         rd_q       <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         opb_q      <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         regwrite_q <= 1'b0;
         result_q   <= '0;
         rd_out_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.funct3;
                  rd_q     <= bus.rd_in;
                  sign_a_q <= neg_a;
                  sign_b_q <= neg_b;
                  opb_q    <= mag_b;
                  acc_q    <= {{XLEN{1'b0}}, mag_a};
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  if (div_zero || div_ovf) begin
                     result_q   <= special_res;
                     rd_out_q   <= bus.rd_in;
                     done_q     <= 1'b1;
                     regwrite_q <= (bus.rd_in != '0);
                     state      <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q   <= acc_step;
               count_q <= count_q + CW'(1);
               if (count_q == CW'(XLEN - 1)) state <= FIX;
            end
            FIX: begin
               result_q   <= fix_res;
               rd_out_q   <= rd_q;
               done_q     <= 1'b1;
               regwrite_q <= (rd_q != '0);
               state      <= DONE;
            end
            DONE: begin
               done_q     <= 1'b0;
               regwrite_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.rd_out       = rd_out_q;
   assign bus.regwrite_out = regwrite_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      longint      sp;
      int          sa;
      int          sb;
      logic        ovf;
      logic [31:0] r;
      sa  = int'(a);
      sb  = int'(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         F3_MUL:    begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
         F3_MULH:   begin sp = longint'(sa) * longint'(sb); p = sp; r = p[63:32]; end
         F3_MULHSU: begin sp = longint'(sa) * longint'({32'h0, b}); p = sp; r = p[63:32]; end
         F3_MULHU:  begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         F3_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default:   r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clock);
      bus.start    = 1'b1;
      bus.funct3   = f3;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_in    = rd;
      @(posedge clock);
      #1;
      bus.start    = 1'b0;
      bus.funct3   = 3'($urandom);
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
      bus.rd_in    = 5'($urandom);
   endtask

   // lat = 1 means done is already visible just after the accept edge
   task automatic wait_done(output int lat);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      int          lat;
      int          exp_lat;
      logic [31:0] exp_res;
      exp_res = model(f3, a, b);
      exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                ? 1 : XLEN + 2;
      issue(f3, a, b, rd);
      check({tag, " busy_after_accept"}, 64'(bus.busy), 64'(1));
      wait_done(lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, 64'(bus.result), 64'(exp_res));
      check({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
      check({tag, " regwrite"}, 64'(bus.regwrite_out), 64'(rd != 0));
      @(posedge clock);
      #1;
      check({tag, " done_drops"}, 64'(bus.done), 64'(0));
      check({tag, " regwrite_drops"}, 64'(bus.regwrite_out), 64'(0));
      check({tag, " busy_drops"}, 64'(bus.busy), 64'(0));
      check({tag, " result_holds"}, 64'(bus.result), 64'(exp_res));
   endtask

   initial begin
      int          lat;
      int          extra;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      bus.start    = 1'b0;
      bus.funct3   = '0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      bus.rd_in    = '0;

      repeat (3) @(posedge clock);
      #1;
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset regwrite", 64'(bus.regwrite_out), 64'(0));
      check("reset result", 64'(bus.result), 64'(0));
      check("reset rd_out", 64'(bus.rd_out), 64'(0));
      @(negedge clock);
      reset = 1'b0;

      run_op("mul_7x6", F3_MUL, 32'd7, 32'd6, 5'd5);
      check("mul_7x6 value", 64'(bus.result), 64'h2A);
      run_op("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      check("mulh_m1 value", 64'(bus.result), 64'h0);
      run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      check("mulhu_max value", 64'(bus.result), 64'hFFFF_FFFE);
      run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3);
      check("mulhsu value", 64'(bus.result), 64'hFFFF_FFFF);
      run_op("div_m7", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
      check("div_m7 value", 64'(bus.result), 64'hFFFF_FFFD);
      run_op("rem_m7", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
      check("rem_m7 value", 64'(bus.result), 64'hFFFF_FFFF);
      run_op("divu_m7", F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd7);
      check("divu_m7 value", 64'(bus.result), 64'h7FFF_FFFC);
      run_op("div_by0", F3_DIV, 32'd5, 32'd0, 5'd8);
      check("div_by0 value", 64'(bus.result), 64'hFFFF_FFFF);
      run_op("remu_by0", F3_REMU, 32'd5, 32'd0, 5'd9);
      check("remu_by0 value", 64'(bus.result), 64'h5);
      run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
      check("div_ovf value", 64'(bus.result), 64'h8000_0000);
      run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      check("rem_ovf value", 64'(bus.result), 64'h0);
      run_op("mul_rd0", F3_MUL, 32'd3, 32'd4, 5'd0);

      // A second start during CALC must be dropped entirely
      issue(F3_MUL, 32'd123, 32'd456, 5'd9);
      repeat (5) @(posedge clock);
      @(negedge clock);
      bus.start    = 1'b1;
      bus.funct3   = F3_DIVU;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd3;
      bus.rd_in    = 5'd4;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      check("ignored_start done_seen", 64'(bus.done), 64'(1));
      check("ignored_start result", 64'(bus.result), 64'(model(F3_MUL, 32'd123, 32'd456)));
      check("ignored_start rd_out", 64'(bus.rd_out), 64'(9));
      extra = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) extra++;
      end
      check("ignored_start extra_done", 64'(extra), 64'(0));

      issue(F3_MUL, 32'd1000, 32'd1000, 5'd7);
      repeat (10) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("abort busy", 64'(bus.busy), 64'(0));
      check("abort done", 64'(bus.done), 64'(0));
      check("abort result", 64'(bus.result), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd12);
      check("divu_100_7 value", 64'(bus.result), 64'd14);

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b, 5'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes the two register read ports (rs1/rs2 data) together with the destination register number. It produces the write-back triple (data, register number, write enable) that feeds the register file write port. The core stalls on `busy` while an operation is in flight. Each operation takes one shift-add or shift-subtract iteration per bit.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; iteration count equals XLEN.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; accepted only while `busy`=0.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  XLEN  operand A (register file read_data1).
- `rs2_data`  in  XLEN  operand B (register file read_data2).
- `rd_in`  in  5  destination register number.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  write-back data.
- `rd_out`  out  5  write-back register number.
- `regwrite_out`  out  1  equals `done` & (`rd_out`≠0).

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: runs XLEN iterations; 5-bit counter.
  - FIX: applies the sign correction to the result.
  - DONE: single cycle; `done`=1; returns to IDLE.
- On accept, the unit latches `funct3` and `rd_in`. It also latches operand magnitudes and sign flags:
  - Signed ops: MUL*/MULH (both operands), MULHSU (rs1 only), DIV/REM (both).
  - Unsigned ops: MULHU, DIVU, REMU.
- Multiply:
  - 2·XLEN-bit shift-add on the magnitudes.
  - The FIX state negates the product when the sign flags differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring shift-subtract on the magnitudes.
  - The quotient is negated when the sign flags differ.
  - The remainder takes the dividend's sign.
- Special cases are resolved at accept. The unit goes straight to DONE, skipping CALC and FIX:
  - Divide by zero: quotient = all ones; remainder = rs1_data.
  - Signed overflow (rs1 = most-negative value, rs2 = −1): quotient = rs1; remainder = 0.
- `start` while `busy`=1 is ignored. There is no queueing and no error flag.
- `result` and `rd_out` hold their values from DONE until the next accept. `done` and `regwrite_out` are high in DONE only.
- rd_in = 0: the operation runs normally and `done` pulses, but `regwrite_out` stays 0.

## Timing
- Reset (asynchronous) forces:
  - state to IDLE;
  - `busy`, `done`, `regwrite_out` to 0;
  - `result` to 0 and `rd_out` to 0;
  - all internal registers to 0.
- Reset mid-operation aborts the operation; the partial result is discarded.
- Let edge E be the edge that samples `start`=1 in IDLE:
  - `busy`=1 from E.
  - CALC occupies the cycles after edges E … E+XLEN−1.
  - FIX follows edge E+XLEN.
  - DONE (`done`=1) follows edge E+XLEN+1.
  - IDLE resumes after edge E+XLEN+2.
- Latency is XLEN+2 cycles from accept to the `done` pulse.
- Special cases: DONE follows edge E; latency is 1 cycle.
- Back-to-back: the next `start` can be sampled at the first edge where `busy`=0, which is one cycle after DONE.
- Operand inputs are sampled only at the accept edge. They may change afterward.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 localparams (`F3_MUL` … `F3_REMU`);
  - state enum `muldiv_state_t` (IDLE, CALC, FIX, DONE);
  - an `XLEN` default constant.
- Single module; no sub-module. The multiply and divide datapaths share one 2·XLEN accumulator/shift register and one XLEN+1-bit adder/subtractor.

## Test plan
- MUL, rs1=7, rs2=6, rd=5 → `done` exactly 34 cycles after accept; `result`=0x0000002A, `rd_out`=5, `regwrite_out`=1 for one cycle.
- High-half multiplies, operands 0xFFFFFFFF × 0xFFFFFFFF unless noted:
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU with rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- Signed divide, rs1=0xFFFFFFF9 (−7), rs2=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
- Special-case divides, each with `done` one cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- MUL with rd=0 → `done` pulses, `regwrite_out` stays 0. A second `start` during CALC is ignored: exactly one `done`, and the result belongs to the first op.
- Assert `reset` in CALC cycle 10 → `busy`/`done` are 0 immediately and `result`=0. A fresh DIVU 100/7 then gives `result`=14 after 34 cycles.
